// File: rtl/icache_responder.sv
// Direct-mapped instruction cache (4-word lines) answering fetch lookups, with word-serial refill.
// Latency: hits return combinationally in the lookup cycle; misses refill one memory beat at a time.
// Backpressure: each memory beat holds mem_req/mem_addr until mem_ack; no lookups are served while refilling.
// Ports: clk/reset (async, active-low); pc_in/rd_en lookup -> dout/dout_valid;
//        abort cancels a refill, inv_all drops every line; mem_req/mem_addr/mem_ack/mem_rdata
//        form the refill port; miss_count counts refills started (saturating).
module icache_responder #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int INDEX_BITS    = 3,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [ADDRESS_WIDTH-1:0]  pc_in,
  input  logic                      rd_en,
  input  logic                      abort,
  input  logic                      inv_all,
  output logic [4*DATA_WIDTH-1:0]   dout,
  output logic                      dout_valid,
  output logic                      mem_req,
  output logic [ADDRESS_WIDTH-1:0]  mem_addr,
  input  logic                      mem_ack,
  input  logic [DATA_WIDTH-1:0]     mem_rdata,
  output logic [CNT_WIDTH-1:0]      miss_count
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = ADDRESS_WIDTH - INDEX_BITS - 2;

  typedef enum logic [1:0] {IDLE, REFILL, DRAIN} state_t;

  state_t                   state;
  logic [LINES-1:0]         valid;
  logic [TAG_W-1:0]         tag_arr  [LINES];
  logic [4*DATA_WIDTH-1:0]  data_arr [LINES];
  logic [DATA_WIDTH-1:0]    line_buf [4];
  logic [1:0]               beat;
  logic                     abort_pend;

  // Lookup address fields; the word offset within the block is ignored.
  logic [INDEX_BITS-1:0]    index;
  logic [TAG_W-1:0]         tag;
  logic                     hit;
  logic                     unused_offset;

  assign index         = pc_in[INDEX_BITS+1:2];
  assign tag           = pc_in[ADDRESS_WIDTH-1:INDEX_BITS+2];
  assign unused_offset = ^pc_in[1:0];
  assign hit           = valid[index] && (tag_arr[index] == tag);
  assign dout_valid    = rd_en && hit && (state == IDLE);
  assign dout          = dout_valid ? data_arr[index] : '0;

  // The refill base only ever advances in its low two bits, so mem_addr itself
  // carries the latched tag and index for the whole refill.
  logic [INDEX_BITS-1:0]    fill_index;
  logic [TAG_W-1:0]         fill_tag;
  logic                     beat_accept;
  logic                     install;

  assign fill_index  = mem_addr[INDEX_BITS+1:2];
  assign fill_tag    = mem_addr[ADDRESS_WIDTH-1:INDEX_BITS+2];
  assign beat_accept = (state == REFILL) && mem_ack && !abort;
  // An invalidate seen at any point of the refill (earlier or this cycle) suppresses the install.
  assign install     = beat_accept && (beat == 2'd3) && !abort_pend && !inv_all;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      beat       <= '0;
      abort_pend <= 1'b0;
      miss_count <= '0;
      valid      <= '0;
    end else begin
      if (inv_all) begin
        valid <= '0;
      end else if (install) begin
        valid[fill_index] <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (rd_en && !hit && !inv_all) begin
            mem_addr   <= {pc_in[ADDRESS_WIDTH-1:2], 2'b00};
            beat       <= '0;
            abort_pend <= 1'b0;
            mem_req    <= 1'b1;
            state      <= REFILL;
            if (miss_count != '1) begin
              miss_count <= miss_count + CNT_WIDTH'(1);
            end
          end
        end
        REFILL: begin
          if (inv_all) begin
            abort_pend <= 1'b1;
          end
          if (mem_ack) begin
            if (abort || (beat == 2'd3)) begin
              mem_req <= 1'b0;
              state   <= IDLE;
            end else begin
              beat     <= beat + 2'd1;
              mem_addr <= mem_addr + ADDRESS_WIDTH'(1);
            end
          end else if (abort) begin
            // The request already on the bus must still be answered.
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= IDLE;
          end
        end
        default: begin
          mem_req <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  // Storage arrays carry no reset; the valid bits gate everything read from them.
  always_ff @(posedge clk) begin
    if (beat_accept) begin
      line_buf[beat] <= mem_rdata;
    end
    if (install) begin
      data_arr[fill_index] <= {mem_rdata, line_buf[2], line_buf[1], line_buf[0]};
      tag_arr[fill_index]  <= fill_tag;
    end
  end

endmodule

// File: tb/tb_icache_responder.sv
// Self-checking bench for icache_responder: memory responder model, reference tag/valid model,
// and a scoreboard of expected line data pushed on predicted hits and popped on dout_valid.
// Inputs are driven 1 ns after the rising edge; outputs are sampled on the falling edge.
module tb_icache_responder;

  logic         clk = 1'b0;
  logic         reset;
  logic [31:0]  pc_in;
  logic         rd_en;
  logic         abort;
  logic         inv_all;
  logic [127:0] dout;
  logic         dout_valid;
  logic         mem_req;
  logic [31:0]  mem_addr;
  logic         mem_ack = 1'b0;
  logic [31:0]  mem_rdata = 32'h0;
  logic [15:0]  miss_count;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  bit           mv [8];
  logic [26:0]  mt [8];
  int           exp_mc = 0;
  int           ack_budget = -1;   // -1: unlimited acks, N>0: N more acks, 0: hold ack low
  int           wait_cnt = 0;
  logic [31:0]  addr_log [$];
  logic [127:0] sb_q [$];

  always #5 clk = ~clk;

  icache_responder dut (
    .clk        (clk),
    .reset      (reset),
    .pc_in      (pc_in),
    .rd_en      (rd_en),
    .abort      (abort),
    .inv_all    (inv_all),
    .dout       (dout),
    .dout_valid (dout_valid),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .miss_count (miss_count)
  );

  // Slow memory: acks two cycles after a request is seen, data = 0xA0 + address.
  always begin
    @(posedge clk);
    #1;
    mem_ack = 1'b0;
    if (!reset || !mem_req) begin
      wait_cnt = 0;
    end else if (ack_budget != 0) begin
      if (wait_cnt >= 2) begin
        mem_ack   = 1'b1;
        mem_rdata = 32'hA0 + mem_addr;
        addr_log.push_back(mem_addr);
        wait_cnt  = 0;
        if (ack_budget > 0) ack_budget--;
      end else begin
        wait_cnt++;
      end
    end
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] blk(input logic [31:0] base);
    logic [127:0] r;
    r = '0;
    for (int k = 0; k < 4; k++) r[k*32 +: 32] = 32'hA0 + base + 32'(k);
    return r;
  endfunction

  function automatic bit mhit(input logic [31:0] pc);
    return mv[pc[4:2]] && (mt[pc[4:2]] == pc[31:5]);
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 8; i++) mv[i] = 1'b0;
  endtask

  // Called 1 ns after a rising edge; leaves the bench 1 ns after the following edge.
  task automatic lookup(input logic [31:0] pc, output bit hit);
    logic [31:0] base;
    base  = {pc[31:2], 2'b00};
    pc_in = pc;
    rd_en = 1'b1;
    hit   = mhit(pc);
    if (hit) sb_q.push_back(blk(base));
    @(negedge clk);
    check("dout_valid", 128'(dout_valid), 128'(hit));
    if (dout_valid) begin
      check("sb_pending", 128'(sb_q.size()), 128'(1));
      if (sb_q.size() > 0) check("dout", dout, sb_q.pop_front());
    end else begin
      check("dout_zero", dout, 128'(0));
      if (hit && sb_q.size() > 0) sb_q.delete(0);
    end
    @(posedge clk);
    #1;
    rd_en = 1'b0;
    if (hit) begin
      check("no_req_on_hit", 128'(mem_req), 128'(0));
    end else begin
      if (exp_mc < 65535) exp_mc++;
      check("miss_req", 128'(mem_req), 128'(1));
      check("miss_addr", 128'(mem_addr), 128'(base));
    end
    check("miss_count", 128'(miss_count), 128'(exp_mc));
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(posedge clk);
      #1;
      if (!mem_req) done = 1'b1;
    end
    check("refill_done", 128'(done), 128'(1));
  endtask

  // mode 0: plain refill and install; 1: inv_all during refill; 2: abort with the last ack.
  task automatic fill(input logic [31:0] pc, input int mode);
    logic [31:0] base;
    bit          hit;
    bit          done;
    base = {pc[31:2], 2'b00};
    addr_log.delete();
    lookup(pc, hit);
    // Mid-refill: an unrelated pc must neither produce data nor move the refill address.
    pc_in   = pc ^ 32'h100;
    rd_en   = 1'b1;
    inv_all = (mode == 1);
    @(negedge clk);
    check("refill_dv", 128'(dout_valid), 128'(0));
    @(posedge clk);
    #1;
    if (mode == 1) begin
      inv_all = 1'b0;
      clear_model();
    end
    pc_in = pc;
    rd_en = (mode == 0);
    if (mode == 2) begin
      done = 1'b0;
      for (int i = 0; i < 100 && !done; i++) begin
        @(posedge clk);
        #2;
        if (mem_ack && mem_addr == base + 32'd3) begin
          abort = 1'b1;
          done  = 1'b1;
        end
      end
      check("beat3_seen", 128'(done), 128'(1));
      @(posedge clk);
      #1;
      abort = 1'b0;
      check("abort_idle", 128'(mem_req), 128'(0));
    end else begin
      wait_idle();
    end
    check("beats", 128'(addr_log.size()), 128'(4));
    for (int k = 0; k < addr_log.size(); k++)
      check("beat_addr", 128'(addr_log[k]), 128'(base + 32'(k)));
    if (mode == 0) begin
      mv[pc[4:2]] = 1'b1;
      mt[pc[4:2]] = pc[31:5];
      lookup(pc, hit);   // first IDLE cycle after the refill
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit hit;
    bit done;
    clear_model();
    reset   = 1'b0;
    pc_in   = 32'h10;
    rd_en   = 1'b1;
    abort   = 1'b0;
    inv_all = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_dout_valid", 128'(dout_valid), 128'(0));
    check("rst_dout", dout, 128'(0));
    check("rst_mem_req", 128'(mem_req), 128'(0));
    check("rst_mem_addr", 128'(mem_addr), 128'(0));
    check("rst_miss_count", 128'(miss_count), 128'(0));
    rd_en = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Cold miss, then hits on other words of the same block
    fill(32'h10, 0);
    lookup(32'h12, hit);
    lookup(32'h13, hit);

    // Conflict on index 4
    fill(32'h30, 0);
    fill(32'h10, 0);
    check("conflict_mc", 128'(miss_count), 128'(3));

    // Abort during beat 1 with ack held low: request drains, nothing installed
    addr_log.delete();
    ack_budget = 1;
    lookup(32'h20, hit);
    done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(posedge clk);
      #2;
      if (addr_log.size() == 1) done = 1'b1;
    end
    check("beat0_ack", 128'(done), 128'(1));
    repeat (2) @(posedge clk);
    #1;
    check("beat1_addr", 128'(mem_addr), 128'(32'h21));
    check("beat1_req", 128'(mem_req), 128'(1));
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("drain_hold", 128'(mem_req), 128'(1));
    check("drain_addr", 128'(mem_addr), 128'(32'h21));
    ack_budget = -1;
    wait_idle();
    check("drain_beats", 128'(addr_log.size()), 128'(2));
    fill(32'h20, 0);

    // Abort together with the final ack, then inv_all during a refill
    fill(32'h64, 2);
    fill(32'h64, 0);
    fill(32'h48, 1);
    fill(32'h10, 0);
    fill(32'h48, 0);

    // inv_all in IDLE blocks a miss in that cycle and drops every line
    pc_in   = 32'h7C;
    rd_en   = 1'b1;
    inv_all = 1'b1;
    @(negedge clk);
    check("inv_idle_dv", 128'(dout_valid), 128'(0));
    @(posedge clk);
    #1;
    rd_en   = 1'b0;
    inv_all = 1'b0;
    clear_model();
    check("inv_blocks_miss", 128'(mem_req), 128'(0));
    check("inv_mc", 128'(miss_count), 128'(exp_mc));
    fill(32'h10, 0);

    // abort in IDLE has no effect on a hit
    abort = 1'b1;
    lookup(32'h11, hit);
    abort = 1'b0;

    // Reset during beat 2
    addr_log.delete();
    lookup(32'h50, hit);
    done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(posedge clk);
      #2;
      if (addr_log.size() == 2) done = 1'b1;
    end
    check("beat1_ack", 128'(done), 128'(1));
    @(posedge clk);
    #1;
    pc_in = 32'h10;
    rd_en = 1'b1;
    reset = 1'b0;
    #1;
    check("mid_rst_req", 128'(mem_req), 128'(0));
    check("mid_rst_dv", 128'(dout_valid), 128'(0));
    check("mid_rst_mc", 128'(miss_count), 128'(0));
    clear_model();
    exp_mc = 0;
    @(posedge clk);
    #1;
    rd_en = 1'b0;
    reset = 1'b1;
    fill(32'h10, 0);
    check("post_rst_mc", 128'(miss_count), 128'(1));

    check("sb_drained", 128'(sb_q.size()), 128'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
